handshake_constant_table: RTL and testbench
===========================================

// Module: handshake_constant_table
// PURPOSE
// - Elastic multi-constant source for Dynamatic-generated dataflow circuits.
// - Holds NUM_CONSTS compile-time constants. Emits one constant per accepted control token.
// - Two modes for choosing the entry:
//   - SEQ: an internal index walks the table.
//   - SEL: the index travels with the token on a side input.
// - One registered output slot breaks the combinational valid/data path between the
//   control producer and the consumer. Used for coefficient/threshold tables in
//   softclip/tanh kernels.
// PARAMETERS
// - DATA_WIDTH   26                          width of each constant and of outs
// - NUM_CONSTS   4                           number of table entries, >=1
// - CONST_TABLE  {26'h2000000,26'h3FFFFFF,   packed table, entry i at bits
//                 26'h0000001,26'h13FDA9F}   [i*DATA_WIDTH +: DATA_WIDTH]
// - MODE         0                           0 = SEQ (internal wrap counter), 1 = SEL (ctrl_sel)
// - IDX_WIDTH    clog2(NUM_CONSTS), min 1    localparam: width of sel/index
// PORTS
// - clk         in   1           clock, rising edge
// - rst         in   1           synchronous reset, active-high
// - ctrl_valid  in   1           control token valid
// - ctrl_ready  out  1           control token accepted when high with ctrl_valid
// - ctrl_sel    in   IDX_WIDTH   entry index, sampled with the token; ignored when MODE=0
// - outs        out  DATA_WIDTH  constant value of the held token
// - outs_idx    out  IDX_WIDTH   table index of the held token
// - outs_valid  out  1           output slot full
// - outs_ready  in   1           consumer ready
// BEHAVIOUR
// - Reset, synchronous on rst=1 at a clock edge:
//   - outs_valid=0, outs=0, outs_idx=0, sequence index=0.
//   - A token held in the slot is discarded.
//   - ctrl_ready is low while rst is high.
// - Accept: acc = ctrl_valid & ctrl_ready.
// - Drain: drn = outs_valid & outs_ready.
// - ctrl_ready = !rst & (!outs_valid | outs_ready). Full throughput of one token per
//   cycle; no combinational path from ctrl_valid to outs_valid.
// - Latency: a token accepted in cycle N appears at outs in cycle N+1.
// - Slot update at each edge (rst=0):
//   - acc=1: outs <= TABLE[idx], outs_idx <= idx, outs_valid <= 1. This covers
//     simultaneous drain and fill.
//   - acc=0 & drn=1: outs_valid <= 0. outs/outs_idx hold their last value.
//   - Otherwise the slot holds.
// - While outs_valid=1 & outs_ready=0, outs and outs_idx are stable. This is the
//   elastic persistence rule.
// - Index selection:
//   - SEQ: idx = seq index. Advances only on acc. Wraps from NUM_CONSTS-1 to 0.
//     With NUM_CONSTS=1 it stays 0.
//   - SEL: idx = ctrl_sel when ctrl_sel < NUM_CONSTS, else 0. An out-of-range index
//     selects entry 0 and reports outs_idx=0.
// - ctrl_sel is ignored unless acc=1. The seq index is untouched in SEL mode.
// - Data arithmetic: none. Table entries pass bit-exact, with no sign or zero
//   extension.
// - Unknown or X ctrl_sel while ctrl_valid=0 must not affect state.
// STRUCTURE
// - Package handshake_pkg:
//   - function clog2_min1(n);
//   - localparams CONST_MODE_SEQ=0 and CONST_MODE_SEL=1.
// - Sub-module handshake_out_slot #(WIDTH):
//   - one-entry output-elastic register with ins/ins_valid/ins_ready and
//     outs/outs_valid/outs_ready;
//   - instantiated with WIDTH=DATA_WIDTH+IDX_WIDTH.
// - Top level contains the table mux, the range check and the seq counter.
// TESTING
// Directed tests use default parameters.
// 1. Reset: rst=1 for 2 cycles with ctrl_valid=1 -> ctrl_ready=0, outs_valid=0, outs=0.
//    After release the first token gives outs=26'h13FDA9F, outs_idx=0.
// 2. SEQ streaming: 6 tokens back-to-back, outs_ready=1 -> one output per cycle:
//    13FDA9F, 0000001, 3FFFFFF, 2000000, 13FDA9F, 0000001. outs_idx=0,1,2,3,0,1.
// 3. Backpressure: slot full, outs_ready=0 for 5 cycles, ctrl_valid=1 ->
//    - ctrl_ready=0 and outs stable for all 5 cycles;
//    - seq index not advanced;
//    - on the outs_ready=1 cycle a drain and a fill happen together.
// 4. SEL mode (MODE=1): ctrl_sel=2,3,1 -> 3FFFFFF, 2000000, 0000001.
//    With NUM_CONSTS=3, ctrl_sel=3 -> 13FDA9F, outs_idx=0.
// 5. Reset mid-operation: slot full at entry 2, seq index=3, then rst pulse ->
//    - outs_valid=0, token lost;
//    - the next token yields entry 0.
// 6. Random valid/ready, 10k cycles, scoreboarded -> no token dropped or duplicated,
//    order preserved, outs stable while stalled.

Source files
------------

// File: rtl/handshake_pkg.sv
// Shared definitions for the handshake constant-table block: mode encodings and
// the index-width helper used to size table indices.
package handshake_pkg;

    localparam int CONST_MODE_SEQ = 0;
    localparam int CONST_MODE_SEL = 1;

    // An index needs at least one bit even for a single-entry table.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/handshake_out_slot.sv
// One-entry output-elastic register: full-throughput slot that registers the
// valid/data path while passing ready straight through.
module handshake_out_slot
    import handshake_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] ins,
    input  logic             ins_valid,
    output logic             ins_ready,
    output logic [WIDTH-1:0] outs,
    output logic             outs_valid,
    input  logic             outs_ready
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             load;

    always_comb begin
        ins_ready = !rst && (!valid_q || outs_ready);
        load      = ins_valid && ins_ready;
        valid_d   = valid_q;
        data_d    = data_q;
        // A load wins over a drain so that simultaneous drain+fill keeps the slot full.
        if (load) begin
            valid_d = 1'b1;
            data_d  = ins;
        end else if (valid_q && outs_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign outs       = data_q;
    assign outs_valid = valid_q;

endmodule

// File: rtl/handshake_constant_table.sv
// Elastic multi-constant source: emits one table entry per accepted control token,
// chosen either by an internal wrapping sequence index or by a side-band select.
module handshake_constant_table
    import handshake_pkg::*;
#(
    parameter int                              DATA_WIDTH  = 26,
    parameter int                              NUM_CONSTS  = 4,
    parameter logic [NUM_CONSTS*DATA_WIDTH-1:0] CONST_TABLE = {26'h2000000, 26'h3FFFFFF,
                                                               26'h0000001, 26'h13FDA9F},
    parameter int                              MODE        = CONST_MODE_SEQ,
    localparam int                             IDX_WIDTH   = clog2_min1(NUM_CONSTS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_valid,
    output logic                  ctrl_ready,
    input  logic [IDX_WIDTH-1:0]  ctrl_sel,
    output logic [DATA_WIDTH-1:0] outs,
    output logic [IDX_WIDTH-1:0]  outs_idx,
    output logic                  outs_valid,
    input  logic                  outs_ready
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CONSTS - 1);

    logic [IDX_WIDTH-1:0]            seq_q;
    logic [IDX_WIDTH-1:0]            seq_d;
    logic [IDX_WIDTH-1:0]            sel_idx;
    logic [IDX_WIDTH-1:0]            idx;
    logic [DATA_WIDTH-1:0]           table_val;
    logic                            acc;
    logic [DATA_WIDTH+IDX_WIDTH-1:0] slot_outs;

    always_comb begin
        // Out-of-range selects fall back to entry 0 and report index 0.
        sel_idx   = (int'(ctrl_sel) < NUM_CONSTS) ? ctrl_sel : '0;
        idx       = (MODE == CONST_MODE_SEL) ? sel_idx : seq_q;
        table_val = CONST_TABLE[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
        acc       = ctrl_valid && ctrl_ready;
        seq_d     = seq_q;
        if ((MODE == CONST_MODE_SEQ) && acc) begin
            seq_d = (seq_q == LAST_IDX) ? '0 : seq_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seq_q <= '0;
        end else begin
            seq_q <= seq_d;
        end
    end

    handshake_out_slot #(
        .WIDTH(DATA_WIDTH + IDX_WIDTH)
    ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .ins       ({idx, table_val}),
        .ins_valid (ctrl_valid),
        .ins_ready (ctrl_ready),
        .outs      (slot_outs),
        .outs_valid(outs_valid),
        .outs_ready(outs_ready)
    );

    assign outs     = slot_outs[DATA_WIDTH-1:0];
    assign outs_idx = slot_outs[DATA_WIDTH +: IDX_WIDTH];

endmodule

// File: tb/tb_handshake_constant_table.sv
// Bench for handshake_constant_table: directed SEQ/SEL scenarios plus a
// scoreboarded random valid/ready run against a small reference model.
module tb_handshake_constant_table;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // SEQ instance (default parameters)
    logic        c_valid, c_ready, o_valid, o_ready;
    logic [1:0]  c_sel, o_idx;
    logic [25:0] o_data;

    // SEL instance, 4 entries
    logic        s_valid, s_ready, so_valid, so_ready;
    logic [1:0]  s_sel, so_idx;
    logic [25:0] so_data;

    // SEL instance, 3 entries
    logic        t_valid, t_ready, to_valid, to_ready;
    logic [1:0]  t_sel, to_idx;
    logic [25:0] to_data;

    int n_tests = 0;
    int n_fail  = 0;

    logic [25:0] tbl [4] = '{26'h13FDA9F, 26'h0000001, 26'h3FFFFFF, 26'h2000000};

    handshake_constant_table dut (
        .clk(clk), .rst(rst), .ctrl_valid(c_valid), .ctrl_ready(c_ready), .ctrl_sel(c_sel),
        .outs(o_data), .outs_idx(o_idx), .outs_valid(o_valid), .outs_ready(o_ready)
    );

    handshake_constant_table #(.MODE(1)) dut_sel (
        .clk(clk), .rst(rst), .ctrl_valid(s_valid), .ctrl_ready(s_ready), .ctrl_sel(s_sel),
        .outs(so_data), .outs_idx(so_idx), .outs_valid(so_valid), .outs_ready(so_ready)
    );

    handshake_constant_table #(
        .NUM_CONSTS(3),
        .CONST_TABLE({26'h3FFFFFF, 26'h0000001, 26'h13FDA9F}),
        .MODE(1)
    ) dut_sel3 (
        .clk(clk), .rst(rst), .ctrl_valid(t_valid), .ctrl_ready(t_ready), .ctrl_sel(t_sel),
        .outs(to_data), .outs_idx(to_idx), .outs_valid(to_valid), .outs_ready(to_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_all();
        rst = 1'b1;
        c_valid = 1'b0; s_valid = 1'b0; t_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; c_valid = 1'b1; o_ready = 1'b1; c_sel = 2'd0;
        for (int i = 0; i < 2; i++) begin
            tick();
            @(negedge clk);
            n_tests++;
            if (c_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl_ready: got %b want 0", c_ready); end
            n_tests++;
            if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_outs_valid: got %b want 0", o_valid); end
            n_tests++;
            if (o_data !== 26'h0) begin n_fail++; $display("FAIL reset_outs: got %h want 0", o_data); end
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (c_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", c_ready); end
        tick();
        c_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (o_valid !== 1'b1 || o_data !== 26'h13FDA9F || o_idx !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_first_token: got v=%b %h idx=%0d want v=1 13fda9f idx=0", o_valid, o_data, o_idx);
        end
        tick();
    endtask

    task automatic test_seq_stream();
        logic [25:0] exp_d [6];
        logic [1:0]  exp_i [6];
        exp_d = '{26'h13FDA9F, 26'h0000001, 26'h3FFFFFF, 26'h2000000, 26'h13FDA9F, 26'h0000001};
        exp_i = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        reset_all();
        o_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            c_valid = 1'b1;
            tick();
            @(negedge clk);
            n_tests++;
            if (o_valid !== 1'b1 || o_data !== exp_d[i] || o_idx !== exp_i[i]) begin
                n_fail++;
                $display("FAIL seq_stream[%0d]: got v=%b %h idx=%0d want v=1 %h idx=%0d",
                         i, o_valid, o_data, o_idx, exp_d[i], exp_i[i]);
            end
        end
        c_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        reset_all();
        o_ready = 1'b0; c_valid = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if (c_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want 0", i, c_ready); end
            n_tests++;
            if (o_valid !== 1'b1 || o_data !== 26'h13FDA9F || o_idx !== 2'd0) begin
                n_fail++;
                $display("FAIL bp_stable[%0d]: got v=%b %h idx=%0d want v=1 13fda9f idx=0", i, o_valid, o_data, o_idx);
            end
            tick();
        end
        o_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (c_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", c_ready); end
        tick();
        c_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (o_valid !== 1'b1 || o_data !== 26'h0000001 || o_idx !== 2'd1) begin
            n_fail++;
            $display("FAIL bp_drain_fill: got v=%b %h idx=%0d want v=1 0000001 idx=1", o_valid, o_data, o_idx);
        end
        tick();
    endtask

    task automatic test_sel_mode();
        logic [1:0]  ssel [3];
        logic [25:0] sexp [3];
        logic [1:0]  tsel [3];
        logic [25:0] texp [3];
        logic [1:0]  tidx [3];
        ssel = '{2'd2, 2'd3, 2'd1};
        sexp = '{26'h3FFFFFF, 26'h2000000, 26'h0000001};
        tsel = '{2'd3, 2'd2, 2'd1};
        texp = '{26'h13FDA9F, 26'h3FFFFFF, 26'h0000001};
        tidx = '{2'd0, 2'd2, 2'd1};
        reset_all();
        so_ready = 1'b1; to_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_sel = ssel[i];
            t_valid = 1'b1; t_sel = tsel[i];
            tick();
            @(negedge clk);
            n_tests++;
            if (so_valid !== 1'b1 || so_data !== sexp[i] || so_idx !== ssel[i]) begin
                n_fail++;
                $display("FAIL sel4[%0d]: got v=%b %h idx=%0d want v=1 %h idx=%0d",
                         i, so_valid, so_data, so_idx, sexp[i], ssel[i]);
            end
            n_tests++;
            if (to_valid !== 1'b1 || to_data !== texp[i] || to_idx !== tidx[i]) begin
                n_fail++;
                $display("FAIL sel3[%0d]: got v=%b %h idx=%0d want v=1 %h idx=%0d",
                         i, to_valid, to_data, to_idx, texp[i], tidx[i]);
            end
        end
        s_valid = 1'b0; s_sel = 2'bxx; so_ready = 1'b0;
        t_valid = 1'b0;
        tick();
        tick();
        @(negedge clk);
        n_tests++;
        if (so_valid !== 1'b1 || so_data !== 26'h0000001 || so_idx !== 2'd1) begin
            n_fail++;
            $display("FAIL sel_x_hold: got v=%b %h idx=%0d want v=1 0000001 idx=1", so_valid, so_data, so_idx);
        end
        so_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_midop();
        reset_all();
        o_ready = 1'b1; c_valid = 1'b1;
        repeat (3) tick();
        c_valid = 1'b0; o_ready = 1'b0;
        @(negedge clk);
        n_tests++;
        if (o_valid !== 1'b1 || o_data !== 26'h3FFFFFF || o_idx !== 2'd2) begin
            n_fail++;
            $display("FAIL midop_pre: got v=%b %h idx=%0d want v=1 3ffffff idx=2", o_valid, o_data, o_idx);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (o_valid !== 1'b0 || o_data !== 26'h0 || o_idx !== 2'd0) begin
            n_fail++;
            $display("FAIL midop_reset: got v=%b %h idx=%0d want v=0 0 idx=0", o_valid, o_data, o_idx);
        end
        c_valid = 1'b1; o_ready = 1'b1;
        tick();
        c_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (o_valid !== 1'b1 || o_data !== 26'h13FDA9F || o_idx !== 2'd0) begin
            n_fail++;
            $display("FAIL midop_next: got v=%b %h idx=%0d want v=1 13fda9f idx=0", o_valid, o_data, o_idx);
        end
        tick();
    endtask

    task automatic test_random();
        logic [27:0] exp_q [$];
        logic [27:0] got, prev, e;
        logic        prev_stall;
        int          m;
        reset_all();
        m = 0; prev_stall = 1'b0; prev = '0;
        for (int cyc = 0; cyc < 10010; cyc++) begin
            if (cyc < 10000) begin
                c_valid = ($urandom_range(0, 3) != 0);
                o_ready = ($urandom_range(0, 2) != 0);
                c_sel   = 2'($urandom);
            end else begin
                c_valid = 1'b0;
                o_ready = 1'b1;
            end
            @(negedge clk);
            got = {o_idx, o_data};
            n_tests++;
            if (c_ready !== (!o_valid || o_ready)) begin
                n_fail++;
                $display("FAIL rnd_ready cyc %0d: got %b want %b", cyc, c_ready, (!o_valid || o_ready));
            end
            if (prev_stall) begin
                n_tests++;
                if (o_valid !== 1'b1 || got !== prev) begin
                    n_fail++;
                    $display("FAIL rnd_stall cyc %0d: got v=%b %h want v=1 %h", cyc, o_valid, got, prev);
                end
            end
            if (o_valid && o_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rnd_extra cyc %0d: got %h want no output", cyc, got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        n_fail++;
                        $display("FAIL rnd_data cyc %0d: got %h want %h", cyc, got, e);
                    end
                end
            end
            if (c_valid && c_ready) begin
                exp_q.push_back({2'(m), tbl[m]});
                m = (m + 1) % 4;
            end
            prev_stall = o_valid && !o_ready;
            prev = got;
            tick();
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rnd_leftover: got %0d pending want 0", exp_q.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        c_valid = 1'b0; c_sel = '0; o_ready = 1'b0;
        s_valid = 1'b0; s_sel = '0; so_ready = 1'b0;
        t_valid = 1'b0; t_sel = '0; to_ready = 1'b0;
        test_reset();
        test_seq_stream();
        test_backpressure();
        test_sel_mode();
        test_reset_midop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
